cordic_post_pipe: RTL



---
 rtl/cordic_post_pkg.sv | 28 ++
 rtl/cordic_post_pipe_if.sv | 36 +++
 rtl/cordic_amp_scale.sv | 45 ++++
 rtl/cordic_post_pipe.sv | 92 +++++++++
 4 files changed

// File: rtl/cordic_post_pkg.sv
// Shared constants, types and helpers for the CORDIC post-processing pipeline.
//   K_INV_Q     : 1/K CORDIC gain compensation in Q0.16 (0.607253)
//   COEF_W      : width of K_INV_Q
//   quadrant_t  : original quadrant id (0..3)
//   phi_rebuild : full-circle angle from octant angle plus folding info
package cordic_post_pkg;

  localparam int unsigned COEF_W = 16;
  localparam logic [COEF_W-1:0] K_INV_Q = 16'd39797;

  typedef logic [1:0] quadrant_t;

  // Undo the pre-processing fold. Works for any angle width up to 31 bits; the
  // caller truncates the result to its own angle width.
  function automatic logic [31:0] phi_rebuild(input int unsigned phi_w,
                                              input logic [31:0]  phi,
                                              input quadrant_t    q,
                                              input logic         exch);
    logic [31:0] quarter;
    logic [31:0] mask;
    logic [31:0] phi1;
    quarter = 32'd1 << (phi_w - 32'd2);
    mask    = (32'd1 << phi_w) - 32'd1;
    phi1    = exch ? (quarter - phi) : phi;
    return (phi1 + 32'(q) * quarter) & mask;
  endfunction

endpackage

// File: rtl/cordic_post_pipe_if.sv
// Stream bundle between the CORDIC core, the post-processing pipe and the sink.
//   master : source/sink side (drives in_* samples and out_ready)
//   slave  : cordic_post_pipe side (drives in_ready and out_* results)
// in_im is carried for debug visibility only.
interface cordic_post_pipe_if
  import cordic_post_pkg::*;
#(
  parameter int unsigned AMP_W = 12,
  parameter int unsigned PHI_W = 11
);

  logic             gain_comp_en;
  logic             in_valid;
  logic             in_ready;
  logic [AMP_W-1:0] in_re;
  logic [AMP_W-1:0] in_im;
  quadrant_t        in_quadrant;
  logic             in_exchanged;
  logic [PHI_W-1:0] in_phi;
  logic             out_valid;
  logic             out_ready;
  logic [AMP_W-1:0] out_amp;
  logic [PHI_W-1:0] out_phi;
  logic             out_err;

  modport master (
    output gain_comp_en, in_valid, in_re, in_im, in_quadrant, in_exchanged, in_phi, out_ready,
    input  in_ready, out_valid, out_amp, out_phi, out_err
  );

  modport slave (
    input  gain_comp_en, in_valid, in_re, in_im, in_quadrant, in_exchanged, in_phi, out_ready,
    output in_ready, out_valid, out_amp, out_phi, out_err
  );

endinterface

// File: rtl/cordic_amp_scale.sv
// Amplitude clamp / gain compensation, split into two combinational halves so
// the pipeline register can sit between them.
//   re_i, gain_en_i    : raw signed real part and gain mode (front half)
//   prod_o             : clamped magnitude times 1/K, or the bare magnitude
//   prod_i, gain_en_s1_i : registered product and gain mode (back half)
//   amp_o              : rounded, saturated unsigned amplitude
module cordic_amp_scale
  import cordic_post_pkg::*;
#(
  parameter int unsigned AMP_W = 12,
  localparam int unsigned PROD_W = AMP_W + COEF_W
) (
  input  logic [AMP_W-1:0]  re_i,
  input  logic              gain_en_i,
  output logic [PROD_W-1:0] prod_o,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              gain_en_s1_i,
  output logic [AMP_W-1:0]  amp_o
);

  localparam logic [AMP_W:0] AmpMax = {1'b0, {AMP_W{1'b1}}};

  logic [AMP_W-1:0] mag;
  logic [PROD_W:0]  rounded;
  logic [AMP_W:0]   scaled;

  always_comb begin
    mag    = re_i[AMP_W-1] ? '0 : re_i;
    prod_o = gain_en_i ? (PROD_W'(mag) * PROD_W'(K_INV_Q)) : PROD_W'(mag);
  end

  // Round half up on the Q0.16 fraction, then saturate to the output width.
  always_comb begin
    rounded = {1'b0, prod_i} + (PROD_W + 1)'(32'd1 << (COEF_W - 1));
    scaled  = rounded[PROD_W:COEF_W];
    if (!gain_en_s1_i) begin
      amp_o = prod_i[AMP_W-1:0];
    end else if (scaled > AmpMax) begin
      amp_o = '1;
    end else begin
      amp_o = scaled[AMP_W-1:0];
    end
  end

endmodule

// File: rtl/cordic_post_pipe.sv
// Two-stage CORDIC post-processing with valid/ready backpressure.
// Rebuilds the full-circle angle from the octant result and produces an
// optionally gain-compensated amplitude plus an error flag.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of cordic_post_pipe_if (input samples, output results)
module cordic_post_pipe
  import cordic_post_pkg::*;
#(
  parameter int unsigned AMP_W = 12,
  parameter int unsigned PHI_W = 11
) (
  input logic               clk,
  input logic               rst_n,
  cordic_post_pipe_if.slave bus
);

  localparam int unsigned PROD_W = AMP_W + COEF_W;

  logic              s1_adv, s2_adv;
  logic              s1_v_q, s2_v_q;
  logic [PHI_W-1:0]  s1_phi_q;
  logic [PROD_W-1:0] s1_prod_q;
  logic              s1_gain_q, s1_err_q;
  logic [AMP_W-1:0]  out_amp_q;
  logic [PHI_W-1:0]  out_phi_q;
  logic              out_err_q;

  logic [PHI_W-1:0]  phi_full;
  logic [PROD_W-1:0] prod;
  logic [AMP_W-1:0]  amp;
  logic              in_err;

  assign s2_adv       = !s2_v_q | bus.out_ready;
  assign s1_adv       = !s1_v_q | s2_adv;
  assign bus.in_ready = s1_adv;

  assign phi_full = PHI_W'(phi_rebuild(PHI_W, 32'(bus.in_phi), bus.in_quadrant,
                                       bus.in_exchanged));
  // Top three angle bits nonzero means the angle is outside the first octant.
  assign in_err   = bus.in_re[AMP_W-1] | (|bus.in_phi[PHI_W-1:PHI_W-3]);

  cordic_amp_scale #(
    .AMP_W(AMP_W)
  ) u_amp_scale (
    .re_i         (bus.in_re),
    .gain_en_i    (bus.gain_comp_en),
    .prod_o       (prod),
    .prod_i       (s1_prod_q),
    .gain_en_s1_i (s1_gain_q),
    .amp_o        (amp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_phi_q  <= '0;
      s1_prod_q <= '0;
      s1_gain_q <= 1'b0;
      s1_err_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_phi_q  <= phi_full;
        s1_prod_q <= prod;
        s1_gain_q <= bus.gain_comp_en;
        s1_err_q  <= in_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      out_amp_q <= '0;
      out_phi_q <= '0;
      out_err_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        out_amp_q <= amp;
        out_phi_q <= s1_phi_q;
        out_err_q <= s1_err_q;
      end
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.out_amp   = out_amp_q;
  assign bus.out_phi   = out_phi_q;
  assign bus.out_err   = out_err_q;

endmodule
